// File: rtl/serial_subtractor.sv
// serial_subtractor: drives an external full-subtractor cell one bit per clock, LSB first,
// collecting the difference in a shift register and the final borrow in bout.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             fs_a,
  output logic             fs_b,
  output logic             fs_c,
  input  logic             fs_diff,
  input  logic             fs_borrow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             borrow_q, borrow_d, bout_q, bout_d;
  logic [CW-1:0]    count_q, count_d;
  logic             shift, last;
  assign shift = state_q == SHIFT;
  assign last  = count_q == CW'(WIDTH - 1);
  assign fs_a  = shift & a_q[0];
  assign fs_b  = shift & b_q[0];
  assign fs_c  = shift & borrow_q;
  assign busy  = shift;
  assign done  = state_q == DONE;
  assign diff  = diff_q;
  assign bout  = bout_q;
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    count_d  = count_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    if (shift) begin
      a_d      = a_q >> 1;
      b_d      = b_q >> 1;
      borrow_d = fs_borrow;
      count_d  = count_q + CW'(1);
      diff_d   = WIDTH'({fs_diff, diff_q} >> 1);
      if (last) begin
        bout_d  = fs_borrow;
        state_d = DONE;
      end
    end else if (start) begin
      a_d      = a;
      b_d      = b;
      borrow_d = bin;
      count_d  = '0;
      state_d  = SHIFT;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      count_q  <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      count_q  <= count_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor controller. Captures two operands and a borrow-in, then feeds the full-subtractor cell one bit per clock, LSB first, through the cell's a/b/c inputs. It consumes the cell's diff/borrow outputs, holding the running borrow in a flip-flop and assembling the difference in a shift register. It sits directly upstream and downstream of the single full-subtractor cell, letting one combinational cell compute WIDTH-bit differences.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE or DONE
- a  in  WIDTH  minuend, captured on accepted start
- b  in  WIDTH  subtrahend, captured on accepted start
- bin  in  1  borrow-in, captured on accepted start
- fs_a  out  1  to cell a: current minuend bit
- fs_b  out  1  to cell b: current subtrahend bit
- fs_c  out  1  to cell c: current borrow
- fs_diff  in  1  from cell diff
- fs_borrow  in  1  from cell borrow
- busy  out  1  high while in SHIFT
- done  out  1  one-cycle pulse when result is valid
- diff  out  WIDTH  result register
- bout  out  1  final borrow-out

## Operation
- Reset: the clock is single; reset is asynchronous and active-low. Asserting rst_n=0 forces state=IDLE, operand shift registers=0, borrow_q=0, count=0, diff=0, bout=0, busy=0, done=0, fs_a=fs_b=fs_c=0.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 loads a_sh←a, b_sh←b, borrow_q←bin, count←0, then → SHIFT. Otherwise stay in IDLE.
- SHIFT, every cycle:
  - Cell drive (combinational): fs_a=a_sh[0], fs_b=b_sh[0], fs_c=borrow_q.
  - On the edge: diff←{fs_diff, diff[WIDTH-1:1]}, borrow_q←fs_borrow, a_sh and b_sh shift right by 1, count←count+1.
  - When count==WIDTH-1, also bout←fs_borrow and → DONE.
- DONE: done=1 for exactly one cycle. start=1 in this cycle is accepted exactly as in IDLE (back-to-back operation, → SHIFT). Otherwise → IDLE.
- Outside SHIFT, fs_a, fs_b and fs_c are 0.
- start in SHIFT is ignored; no queuing.
- Arithmetic: diff = (a − b − bin) mod 2^WIDTH, and bout = 1 iff a < b + bin (unsigned compare).
- diff and bout hold their values after DONE until the next accepted start begins shifting.
- diff is only meaningful when done=1 or afterwards. Its intermediate values during SHIFT are partial and unspecified to consumers.
- count is ceil(log2(WIDTH))-wide, minimum 1 bit. WIDTH=1 is legal: one SHIFT cycle, then DONE.
- Reset mid-operation aborts immediately. No done is produced for the aborted operation.

## Timing
- Edge 0 samples start=1 → busy=1 after edge 0.
- Edges 1..WIDTH process bits 0..WIDTH-1.
- After edge WIDTH: busy=0, done=1, diff/bout valid. After edge WIDTH+1: done=0.
- Latency from the start-sampling edge to done: WIDTH cycles. Throughput: one result per WIDTH+1 cycles when start is held or re-asserted in DONE.
- The fs_* paths are combinational. The full-subtractor cell's outputs must settle within one clock period, because the edge samples them in the same cycle.
- rst_n deassertion is synchronised externally. The block does not act on start in the first cycle after release unless start is high at that edge.

## Test plan
The bench instantiates the block with WIDTH=8 and a behavioural full-subtractor cell (diff=a^b^c, borrow=(!a&b)|(!(a^b)&c)).
- a=0x5A, b=0x3C, bin=0, start pulsed at edge 0 → busy edges 0–8, done=1 after edge 8 only, diff=0x1E, bout=0.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1. Then a=0xFF, b=0xFF, bin=1 → diff=0xFF, bout=1.
- start asserted again at edges 3 and 5 during SHIFT with different operands → ignored; result is still the first operation's, done pulses exactly once.
- start held high continuously with a=0x10, b=0x01, bin=0 → done pulses every 9 cycles, each diff=0x0F, bout=0, busy never idles more than the DONE cycle.
- rst_n pulled low at edge 4 of an operation → all outputs read 0 immediately. After release with start=0 → no done ever appears. A new start=1 then yields the correct result.
- Random sweep: 1000 random (a, b, bin) → diff and bout match the mod-256 reference. Repeat the suite at WIDTH=1: a=0, b=1, bin=0 → diff=1, bout=1, done 1 cycle after start.
